// File: rtl/neural_network_act_interp.sv
// Activation LUT read side: drives the LUT address from the incoming sample and
// linearly interpolates between base and next entries through a 2-stage pipeline.
module neural_network_act_interp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x_in,
    input  logic              x_valid,
    output logic              x_ready,
    output logic [ADDR_W-1:0] lut_address,
    input  logic [DATA_W-1:0] lut_base,
    input  logic [DATA_W-1:0] lut_next,
    output logic [DATA_W-1:0] y_out,
    output logic              y_valid,
    input  logic              y_ready
);
    localparam int FRAC_W = DATA_W - ADDR_W;
    localparam int PW     = DATA_W + FRAC_W + 2;

    logic              rdy_en;
    logic              s1_valid;
    logic              s2_valid;
    logic [DATA_W-1:0] base_q;
    logic [DATA_W-1:0] next_q;
    logic [FRAC_W-1:0] frac_q;
    logic [DATA_W-1:0] y_q;

    logic              adv2;
    logic              accept;

    logic signed [DATA_W:0] diff;
    logic signed [FRAC_W:0] frac_s;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shifted;
    logic signed [PW-1:0]   sum;
    logic [DATA_W-1:0]      sat;

    assign lut_address = x_in[DATA_W-1 -: ADDR_W];

    // rdy_en holds x_ready low for the first cycle after reset release
    assign adv2    = s1_valid & (~s2_valid | y_ready);
    assign x_ready = rdy_en & (~s1_valid | adv2);
    assign accept  = x_valid & x_ready;

    assign y_valid = s2_valid;
    assign y_out   = y_q;

    always_comb begin
        diff    = $signed({next_q[DATA_W-1], next_q}) - $signed({base_q[DATA_W-1], base_q});
        frac_s  = $signed({1'b0, frac_q});
        prod    = PW'(diff) * PW'(frac_s);
        shifted = prod >>> FRAC_W;
        sum     = PW'($signed(base_q)) + shifted;
        sat     = sum[DATA_W-1:0];
        // Out of range when the bits above the result sign are not all copies of it
        if (sum[PW-1] && !(&sum[PW-1:DATA_W-1])) begin
            sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else if (!sum[PW-1] && (|sum[PW-1:DATA_W-1])) begin
            sat = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en   <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            base_q   <= '0;
            next_q   <= '0;
            frac_q   <= '0;
            y_q      <= '0;
        end else begin
            rdy_en <= 1'b1;

            if (accept) begin
                base_q   <= lut_base;
                next_q   <= lut_next;
                frac_q   <= x_in[FRAC_W-1:0];
                s1_valid <= 1'b1;
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end

            if (adv2) begin
                y_q      <= sat;
                s2_valid <= 1'b1;
            end else if (y_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule
